// File: rtl/picorv32_bus_router.sv
// PicoRV32 native-bus router: decodes each request onto one of three slaves,
// returns a registered response and turns faults into error responses.
module picorv32_bus_router #(
  parameter logic [31:0] PROG_BASE = 32'h0010_0000,
  parameter logic [31:0] PROG_MASK = 32'hFFF0_0000,
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter logic [31:0] RAM_MASK  = 32'hFFFF_0000,
  parameter logic [31:0] PER_BASE  = 32'h0000_0000,
  parameter logic [31:0] PER_MASK  = 32'hF000_0000,
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic [2:0]  s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [2:0]  s_ready,
  input  logic [31:0] s_rdata0,
  input  logic [31:0] s_rdata1,
  input  logic [31:0] s_rdata2,
  output logic        err_flag,
  output logic [31:0] err_addr,
  output logic [7:0]  err_count,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    IDLE, ACTIVE, ERROR, DONE
  } state_t;

  state_t      state;
  logic [1:0]  sel;
  logic [7:0]  cnt;
  logic        hit_prog;
  logic        hit_ram;
  logic        hit_per;
  logic        sel_ready;
  logic [31:0] sel_rdata;

  assign hit_prog = (mem_addr & PROG_MASK) == PROG_BASE;
  assign hit_ram  = (mem_addr & RAM_MASK) == RAM_BASE;
  assign hit_per  = (mem_addr & PER_MASK) == PER_BASE;

  assign s_addr  = mem_addr;
  assign s_wdata = mem_wdata;
  assign s_wstrb = mem_wstrb;

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = s_rdata0;
    case (sel)
      2'd0: begin
        sel_ready = s_ready[0];
        sel_rdata = s_rdata0;
      end
      2'd1: begin
        sel_ready = s_ready[1];
        sel_rdata = s_rdata1;
      end
      default: begin
        sel_ready = s_ready[2];
        sel_rdata = s_rdata2;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 2'd0;
      cnt       <= 8'd0;
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
      s_valid   <= 3'b000;
      err_flag  <= 1'b0;
      err_addr  <= 32'd0;
      err_count <= 8'd0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          // Regions overlap; earlier tests take priority.
          if (mem_valid) begin
            if (hit_prog && mem_wstrb != 4'h0) begin
              state <= ERROR;
            end else if (hit_prog) begin
              sel     <= 2'd0;
              s_valid <= 3'b001;
              state   <= ACTIVE;
            end else if (hit_ram) begin
              sel     <= 2'd1;
              s_valid <= 3'b010;
              state   <= ACTIVE;
            end else if (hit_per) begin
              sel     <= 2'd2;
              s_valid <= 3'b100;
              state   <= ACTIVE;
            end else begin
              state <= ERROR;
            end
          end
        end
        ACTIVE: begin
          cnt <= cnt + 8'd1;
          if (sel_ready) begin
            mem_rdata <= sel_rdata;
            mem_ready <= 1'b1;
            s_valid   <= 3'b000;
            state     <= DONE;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            s_valid <= 3'b000;
            state   <= ERROR;
          end
        end
        ERROR: begin
          mem_rdata <= ERR_DATA;
          mem_ready <= 1'b1;
          state     <= DONE;
        end
        default: begin
          cnt   <= 8'd0;
          state <= IDLE;
        end
      endcase

      // A same-cycle clear swallows the error event.
      if (err_clr) begin
        err_flag  <= 1'b0;
        err_addr  <= 32'd0;
        err_count <= 8'd0;
      end else if (state == ERROR) begin
        if (!err_flag) err_addr <= mem_addr;
        err_flag <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_picorv32_bus_router.sv
// Bench for picorv32_bus_router: a transaction-level model schedules the
// expected per-cycle outputs; one negedge process compares against them.
module tb_picorv32_bus_router;

  localparam int TO = 16;
  localparam int N  = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic [2:0]  s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [2:0]  s_ready = '0;
  logic [31:0] rd0 = '0;
  logic [31:0] rd1 = '0;
  logic [31:0] rd2 = '0;
  logic        err_flag;
  logic [31:0] err_addr;
  logic [7:0]  err_count;
  logic        err_clr = 1'b0;

  picorv32_bus_router dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .s_valid(s_valid), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready),
    .s_rdata0(rd0), .s_rdata1(rd1), .s_rdata2(rd2),
    .err_flag(err_flag), .err_addr(err_addr),
    .err_count(err_count), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  bit [2:0]  e_sv [N];
  bit        e_rdy[N];
  bit [31:0] e_dat[N];
  bit        e_flg[N];
  bit [31:0] e_adr[N];
  bit [7:0]  e_cnt[N];

  bit        m_flag;
  bit [31:0] m_addr;
  int        m_cnt;

  int total = 0;
  int bad = 0;
  bit chk = 0;
  int t0;
  int cur_dly;
  bit noise = 0;
  int n[3];
  int last_run;
  int lat;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic int target(logic [31:0] a, logic [3:0] w);
    if (a >= 32'h0010_0000 && a < 32'h0020_0000) return (w == 4'h0) ? 0 : -1;
    if (a < 32'h0001_0000) return 1;
    if (a < 32'h1000_0000) return 2;
    return -1;
  endfunction

  task automatic fill_err(int from);
    for (int i = from; i < N; i++) begin
      e_flg[i] = m_flag;
      e_adr[i] = m_addr;
      e_cnt[i] = 8'(m_cnt);
    end
  endtask

  // Slaves: raise ready once valid has been seen for dly+1 cycles.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (s_valid[i] === 1'b1) n[i]++;
      else begin
        if (n[i] != 0) last_run = n[i];
        n[i] = 0;
      end
      s_ready[i] = (s_valid[i] === 1'b1 && n[i] >= cur_dly + 1) ||
                   (noise && s_valid[i] !== 1'b1);
    end
  end

  always @(negedge clk) begin
    if (chk && cyc < N) begin
      check("s_valid", {29'd0, s_valid}, {29'd0, e_sv[cyc]});
      check("mem_ready", {31'd0, mem_ready}, {31'd0, e_rdy[cyc]});
      if (e_rdy[cyc]) check("mem_rdata", mem_rdata, e_dat[cyc]);
      check("err_flag", {31'd0, err_flag}, {31'd0, e_flg[cyc]});
      check("err_addr", err_addr, e_adr[cyc]);
      check("err_count", {24'd0, err_count}, {24'd0, e_cnt[cyc]});
      if (s_valid != 3'b000) begin
        check("s_addr", s_addr, mem_addr);
        check("s_wdata", s_wdata, mem_wdata);
        check("s_wstrb", {28'd0, s_wstrb}, {28'd0, mem_wstrb});
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input int dly,
                       input logic [31:0] dat, input bit clr);
    int tgt;
    int done;
    bit err;
    t0 = cyc;
    mem_addr = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    mem_valid = 1'b1;
    err_clr = clr;
    cur_dly = dly;
    tgt = target(a, ws);
    rd0 = (tgt == 0) ? dat : ~dat;
    rd1 = (tgt == 1) ? dat : ~dat;
    rd2 = (tgt == 2) ? dat : ~dat;
    err = 1'b0;
    if (tgt < 0) begin
      done = t0 + 2;
      err = 1'b1;
    end else if (dly <= TO - 1) begin
      for (int c = t0 + 1; c <= t0 + 1 + dly; c++) e_sv[c] = 3'(1 << tgt);
      done = t0 + 2 + dly;
    end else begin
      for (int c = t0 + 1; c <= t0 + TO; c++) e_sv[c] = 3'(1 << tgt);
      done = t0 + TO + 2;
      err = 1'b1;
    end
    e_rdy[done] = 1'b1;
    e_dat[done] = err ? 32'hDEAD_BEEF : dat;
    if (clr) begin
      m_flag = 0;
      m_addr = 0;
      m_cnt = 0;
      fill_err(t0 + 1);
    end else if (err) begin
      if (!m_flag) m_addr = a;
      m_flag = 1;
      if (m_cnt < 255) m_cnt++;
      fill_err(done);
    end
  endtask

  task automatic wait_done(output int l);
    l = -1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (mem_ready === 1'b1) begin
        l = cyc - t0;
        mem_valid = 1'b0;
        err_clr = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL wait_done cyc=%0d got=no_ready want=ready", cyc);
    mem_valid = 1'b0;
    err_clr = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk = 1;
    check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(32'h0010_0008, 32'd0, 4'h0, 1, 32'h0000_0213, 0);
    wait_done(lat);
    check("t1_lat", 32'(lat), 32'd3);
    check("t1_rdata", mem_rdata, 32'h0000_0213);
    check("t1_errcnt", {24'd0, err_count}, 32'd0);

    noise = 1;
    issue(32'h0000_0004, 32'h0000_1770, 4'hF, 1, 32'h0000_0055, 0);
    @(posedge clk);
    #1;
    check("t2_sv", {29'd0, s_valid}, 32'd2);
    check("t2_wdata", s_wdata, 32'h0000_1770);
    wait_done(lat);
    check("t2_lat", 32'(lat), 32'd3);
    check("t2_errcnt", {24'd0, err_count}, 32'd0);
    noise = 0;

    issue(32'h0600_0000, 32'd0, 4'h0, 2, 32'hA5A5_0001, 0);
    wait_done(lat);
    check("t3a_lat", 32'(lat), 32'd4);
    check("t3a_rdata", mem_rdata, 32'hA5A5_0001);
    issue(32'h0700_0000, 32'h0000_1234, 4'h3, 0, 32'h0000_0000, 0);
    wait_done(lat);
    check("t3b_lat", 32'(lat), 32'd2);

    issue(32'h0010_0000, 32'h0000_00FF, 4'hF, 0, 32'h0, 0);
    wait_done(lat);
    check("t4a_lat", 32'(lat), 32'd2);
    check("t4a_rdata", mem_rdata, 32'hDEAD_BEEF);
    issue(32'h1000_0000, 32'd0, 4'h0, 0, 32'h0, 0);
    wait_done(lat);
    check("t4b_lat", 32'(lat), 32'd2);
    check("t4b_rdata", mem_rdata, 32'hDEAD_BEEF);
    check("t4_err_addr", err_addr, 32'h0010_0000);
    check("t4_err_count", {24'd0, err_count}, 32'd2);

    issue(32'h0200_0000, 32'd0, 4'h0, 100, 32'h1111_2222, 0);
    wait_done(lat);
    check("t5_lat", 32'(lat), 32'd18);
    check("t5_rdata", mem_rdata, 32'hDEAD_BEEF);
    check("t5_run", 32'(last_run), 32'd16);
    check("t5_err_count", {24'd0, err_count}, 32'd3);
    check("t5_err_flag", {31'd0, err_flag}, 32'd1);

    issue(32'h0300_0010, 32'd0, 4'h0, TO - 1, 32'h0BAD_F00D, 0);
    wait_done(lat);
    check("t6_lat", 32'(lat), 32'd17);
    check("t6_rdata", mem_rdata, 32'h0BAD_F00D);

    issue(32'hF000_0000, 32'd0, 4'h0, 0, 32'h0, 1);
    wait_done(lat);
    check("t7_rdata", mem_rdata, 32'hDEAD_BEEF);
    check("t7_err_count", {24'd0, err_count}, 32'd0);
    check("t7_err_flag", {31'd0, err_flag}, 32'd0);

    issue(32'h2000_0004, 32'd0, 4'h0, 0, 32'h0, 0);
    wait_done(lat);
    check("t8_err_addr", err_addr, 32'h2000_0004);
    issue(32'h0010_0040, 32'd0, 4'h0, 100, 32'h7777_0000, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    mem_valid = 1'b0;
    m_flag = 0;
    m_addr = 0;
    m_cnt = 0;
    for (int i = cyc + 1; i < N; i++) begin
      e_sv[i] = '0;
      e_rdy[i] = 1'b0;
    end
    fill_err(cyc + 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t8_sv", {29'd0, s_valid}, 32'd0);
    check("t8_rdy", {31'd0, mem_ready}, 32'd0);
    check("t8_flag", {31'd0, err_flag}, 32'd0);
    check("t8_cnt", {24'd0, err_count}, 32'd0);
    check("t8_addr", err_addr, 32'd0);
    check("t8_rdata", mem_rdata, 32'd0);
    @(posedge clk);
    #1;

    issue(32'h0010_0100, 32'd0, 4'h0, 0, 32'h0000_0093, 0);
    wait_done(lat);
    check("t9_lat", 32'(lat), 32'd2);
    check("t9_rdata", mem_rdata, 32'h0000_0093);
    check("t9_run", 32'(last_run), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
